instr_fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the control unit.
- Holds the PC and issues single-outstanding requests to instruction memory.
- Presents the fetched word plus its 6-bit opcode field; the opcode drives the control unit's control_signal input.
- Applies branch/jump redirects reported for the instruction currently presented.

---
 rtl/instr_fetch_unit.sv | 125 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - single-outstanding instruction fetch stage with branch/jump redirect
// Optional IFU_PERF_CNT_EN adds fetch and stall performance counters.
module instr_fetch_unit #(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                HOLD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [15:0]       br_offset,
    input  logic              jump_en,
    input  logic [25:0]       jump_index,
    output logic [31:0]       instr_out,
    output logic              instr_valid,
    output logic [5:0]        opcode_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus4
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [2:0] HOLD_MAX = 3'(HOLD_CYCLES);

    logic [1:0]        state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [2:0]        hold_cnt;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_tgt;

    logic [ADDR_W-1:0] br_disp;
    logic [ADDR_W-1:0] jump_tgt;
    logic [ADDR_W-1:0] redir_tgt;
    logic              redir_now;
    logic              hold_done;

    assign imem_req   = (state == S_REQ);
    assign imem_addr  = fetch_pc;
    assign pc_plus4   = pc_out + ADDR_W'(4);
    // 6'h3F is undecoded downstream; 6'd0 would look like an R-type write
    assign opcode_out = instr_valid ? instr_out[31:26] : 6'h3F;

    assign br_disp   = {{(ADDR_W-18){br_offset[15]}}, br_offset, 2'b00};
    assign jump_tgt  = {pc_plus4[ADDR_W-1:28], jump_index, 2'b00};
    assign redir_now = jump_en | br_taken;
    assign redir_tgt = jump_en ? jump_tgt : (pc_plus4 + br_disp);
    assign hold_done = (hold_cnt == HOLD_MAX) && !stall;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_BOOT;
            fetch_pc    <= RESET_PC;
            hold_cnt    <= 3'd0;
            instr_out   <= 32'd0;
            instr_valid <= 1'b0;
            pc_out      <= '0;
            pend_valid  <= 1'b0;
            pend_tgt    <= '0;
        end else begin
            case (state)
                S_BOOT: state <= S_REQ;
                S_REQ: begin
                    if (imem_ack) begin
                        instr_out   <= imem_rdata;
                        pc_out      <= fetch_pc;
                        instr_valid <= 1'b1;
                        fetch_pc    <= fetch_pc + ADDR_W'(4);
                        hold_cnt    <= 3'd1;
                        state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (hold_cnt != HOLD_MAX) begin
                        hold_cnt <= hold_cnt + 3'd1;
                    end
                    // First redirect seen while presented wins; later ones are dropped
                    if (!pend_valid && redir_now) begin
                        pend_valid <= 1'b1;
                        pend_tgt   <= redir_tgt;
                    end
                    if (hold_done) begin
                        instr_valid <= 1'b0;
                        pend_valid  <= 1'b0;
                        state       <= S_REQ;
                        if (pend_valid) begin
                            fetch_pc <= pend_tgt;
                        end else if (redir_now) begin
                            fetch_pc <= redir_tgt;
                        end
                    end
                end
                default: state <= S_BOOT;
            endcase
        end
    end

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_fetch_cnt <= 32'd0;
            perf_stall_cnt <= 32'd0;
        end else begin
            if (state == S_REQ && imem_ack) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (state == S_HOLD && hold_cnt == HOLD_MAX && stall) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit with a program-flow reference model
module tb_instr_fetch_unit;

    localparam int HOLD = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        br_taken;
    logic [15:0] br_offset;
    logic        jump_en;
    logic [25:0] jump_index;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic [5:0]  opcode_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(RST_PC), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .br_taken(br_taken), .br_offset(br_offset),
        .jump_en(jump_en), .jump_index(jump_index),
        .instr_out(instr_out), .instr_valid(instr_valid), .opcode_out(opcode_out),
        .pc_out(pc_out), .pc_plus4(pc_plus4)
`ifdef IFU_PERF_CNT_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w;
        int          dly;
        int          nst;
        int          rt;
        logic [15:0] off;
        logic [25:0] idx;
        int          rc;
    } plan_t;

    int errors = 0;
    int checks = 0;
    logic [63:0] sb_q[$];
    logic [31:0] exp_pc;
    int exp_fetch = 0;
    int exp_stall = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic plan_t mk(logic [31:0] w, int dly, int nst, int rt,
                                 logic [15:0] off, logic [25:0] idx, int rc);
        plan_t p;
        p.w = w; p.dly = dly; p.nst = nst; p.rt = rt; p.off = off; p.idx = idx; p.rc = rc;
        return p;
    endfunction

    function automatic logic [31:0] br_target(logic [31:0] pc, logic [15:0] off);
        logic signed [31:0] so;
        so = {{16{off[15]}}, off};
        return pc + 32'd4 + 32'(so * 4);
    endfunction

    function automatic logic [31:0] jmp_target(logic [31:0] pc, logic [25:0] idx);
        return ((pc + 32'd4) & 32'hF000_0000) | ({6'd0, idx} * 32'd4);
    endfunction

    // rt: 0 none, 1 branch, 2 jump, 3 both together, 4 branch then jump, 5 jump then branch
    function automatic logic [31:0] next_pc(logic [31:0] pc, plan_t p);
        case (p.rt)
            1, 4:    return br_target(pc, p.off);
            2, 3, 5: return jmp_target(pc, p.idx);
            default: return pc + 32'd4;
        endcase
    endfunction

    task automatic wait_req(input string name);
        int n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(imem_req), 32'd1);
    endtask

    task automatic do_instr(input plan_t p);
        int ncyc;
        logic [31:0] cur;
        wait_req("req_timeout");
        chk("imem_addr", imem_addr, exp_pc);
        repeat (p.dly) begin
            @(negedge clk);
            chk("req_held", {31'd0, imem_req}, 32'd1);
        end
        imem_ack   = 1'b1;
        imem_rdata = p.w;
        sb_q.push_back({exp_pc, p.w});
        cur = exp_pc;
        exp_fetch++;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        ncyc = HOLD + p.nst;
        exp_stall += p.nst;
        for (int k = 0; k < ncyc; k++) begin
            chk("hold_valid", {31'd0, instr_valid}, 32'd1);
            chk("hold_no_req", {31'd0, imem_req}, 32'd0);
            stall      = (k >= HOLD - 1) && (k < HOLD - 1 + p.nst);
            br_taken   = ((p.rt == 1 || p.rt == 3 || p.rt == 4) && k == p.rc) || (p.rt == 5 && k == p.rc + 1);
            jump_en    = ((p.rt == 2 || p.rt == 3 || p.rt == 5) && k == p.rc) || (p.rt == 4 && k == p.rc + 1);
            br_offset  = p.off;
            jump_index = p.idx;
            if (k != p.rc && k != p.rc + 1) begin
                br_offset  = 16'($urandom);
                jump_index = 26'($urandom);
            end
            imem_ack   = ($urandom_range(0, 5) == 0);
            imem_rdata = $urandom;
            @(negedge clk);
        end
        stall = 1'b0; br_taken = 1'b0; jump_en = 1'b0; imem_ack = 1'b0;
        chk("exit_valid", {31'd0, instr_valid}, 32'd0);
        exp_pc = next_pc(cur, p);
    endtask

    // Monitor: pops the scoreboard whenever a new instruction is presented
    initial begin : monitor
        logic        prev = 1'b0;
        logic [63:0] e;
        logic [31:0] l_instr, l_pc;
        logic [5:0]  l_op;
        l_instr = '0; l_pc = '0; l_op = '0;
        forever begin
            @(negedge clk);
            if (instr_valid && !prev) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_instr: got %h expected none", instr_out);
                end else begin
                    e = sb_q.pop_front();
                    chk("instr_out", instr_out, e[31:0]);
                    chk("pc_out", pc_out, e[63:32]);
                    chk("opcode_out", {26'd0, opcode_out}, {26'd0, e[31:26]});
                    chk("pc_plus4", pc_plus4, e[63:32] + 32'd4);
                end
                l_instr = instr_out; l_pc = pc_out; l_op = opcode_out;
            end else if (instr_valid) begin
                chk("stable_instr", instr_out, l_instr);
                chk("stable_pc", pc_out, l_pc);
                chk("stable_opcode", {26'd0, opcode_out}, {26'd0, l_op});
            end else begin
                chk("bubble_opcode", {26'd0, opcode_out}, 32'h3F);
            end
            prev = instr_valid;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        plan_t dir[$];
        plan_t p;
        rst = 1'b0; imem_ack = 1'b0; imem_rdata = '0; stall = 1'b0;
        br_taken = 1'b0; br_offset = '0; jump_en = 1'b0; jump_index = '0;
        repeat (3) @(negedge clk);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, RST_PC);
        chk("rst_instr", instr_out, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_opcode", {26'd0, opcode_out}, 32'h3F);
        chk("rst_pc", pc_out, 32'd0);
        // Ack during the boot cycle must be ignored
        rst = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        exp_pc = RST_PC;

        dir.push_back(mk(32'h8C08_0004, 0, 0, 0, 16'h0, 26'h0, 0));
        dir.push_back(mk(32'h2002_0001, 0, 5, 0, 16'h0, 26'h0, 0));
        dir.push_back(mk(32'h0800_0004, 1, 0, 2, 16'h0, 26'h4, 0));
        dir.push_back(mk(32'h1000_FFFC, 0, 0, 1, 16'hFFFC, 26'h0, 0));
        dir.push_back(mk(32'h0800_0004, 2, 0, 2, 16'h0, 26'h4, 1));
        dir.push_back(mk(32'h1000_0003, 0, 0, 1, 16'h0003, 26'h0, 0));
        dir.push_back(mk(32'h1000_8000, 0, 1, 1, 16'h8000, 26'h0, 2));
        dir.push_back(mk(32'h0C00_0040, 0, 0, 3, 16'h0001, 26'h40, 0));
        dir.push_back(mk(32'h1000_0010, 3, 2, 4, 16'h0010, 26'h5, 0));
        dir.push_back(mk(32'h0BFF_FFFF, 0, 0, 2, 16'h0, 26'h3FF_FFFF, 1));
        dir.push_back(mk(32'hFFFF_FFFF, 0, 0, 0, 16'h0, 26'h0, 0));
        foreach (dir[i]) do_instr(dir[i]);

        // Reset while a request is outstanding; acks during reset are discarded
        wait_req("rst_mid_req");
        imem_ack = 1'b1;
        imem_rdata = $urandom;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_req_drop", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("rst_mid_addr", imem_addr, RST_PC);
        exp_pc = RST_PC;
        exp_fetch = 0;
        exp_stall = 0;

        for (int n = 0; n < 150; n++) begin
            p.w   = $urandom;
            p.dly = $urandom_range(0, 3);
            p.nst = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
            p.rt  = $urandom_range(0, 5);
            p.off = 16'($urandom);
            p.idx = 26'($urandom);
            p.rc  = $urandom_range(0, HOLD + p.nst - 1);
            do_instr(p);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
`ifdef IFU_PERF_CNT_EN
        chk("perf_fetch_cnt", perf_fetch_cnt, 32'(exp_fetch));
        chk("perf_stall_cnt", perf_stall_cnt, 32'(exp_stall));
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
